// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART path. Holds the
//             auto-baud FSM state encoding, the number of additional falling
//             edges that span 8 bit times of a 0x55 character, and the shift
//             that turns an 8-bit span into one bit period.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HIGH = 3'd1,
        WAIT_EDGE = 3'd2,
        MEASURE   = 3'd3,
        EVAL      = 3'd4,
        FAIL      = 3'd5
    } autobaud_state_t;

    // 0x55 sent LSB first falls at start, d1, d3, d5, d7: after the first
    // edge, four more edges close an 8-bit-time window.
    localparam int AB_EDGES = 4;
    localparam int AB_SHIFT = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fall_det.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fall_det
//  Purpose  : Two-flop synchronizer for an asynchronous, idle-high line plus
//             a one-cycle falling-edge pulse on the synchronized level.
//             Every edge passes through the same fixed pipeline, so
//             intervals between pulses equal intervals on the pin.
//  Ports    : clk_in   - system clock
//             rst      - synchronous active-high reset
//             d_i      - asynchronous input line
//             level_o  - synchronized level
//             fall_o   - one-cycle pulse when level_o goes 1 -> 0
//  Revision : 1.0  initial release
// ============================================================================
module sync_fall_det (
    input  logic clk_in,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle-high level so leaving reset never fakes an edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule : sync_fall_det
`default_nettype wire

// File: rtl/uart_autobaud.sv
`default_nettype none
// ============================================================================
//  Module   : uart_autobaud
//  Purpose  : Auto-baud detector. Once armed, measures the span from the
//             first to the fifth falling edge of a 0x55 calibration
//             character (8 bit times) and loads the rounded bit period, in
//             clk_in cycles, as the UART divisor.
//  Ports    : clk_in   - system clock
//             rst      - synchronous active-high reset
//             rx_in    - asynchronous serial line, idle high
//             start    - one-cycle arm pulse (honoured only when idle)
//             busy     - high from accepted start until done or err
//             done     - one-cycle pulse when a new baud_div is loaded
//             err      - one-cycle pulse on a failed measurement
//             valid    - sticky, baud_div holds a measured value
//             baud_div - bit period in clk_in cycles
//  Revision : 1.0  initial release
// ============================================================================
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int MIN_BIT     = 4,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        rx_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        valid,
    output logic [15:0] baud_div
);

    // Rounding adder needs room for total (CNT_W+1 bits) plus the half-LSB.
    localparam int              DW      = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]      LAST_EDGE = 3'(AB_EDGES - 1);

    logic rx_lvl;
    logic rx_fall;

    sync_fall_det u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .d_i     (rx_in),
        .level_o (rx_lvl),
        .fall_o  (rx_fall)
    );

    autobaud_state_t   state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [2:0]        edge_cnt_q, edge_cnt_d;
    logic [CNT_W:0]    total_q,    total_d;
    logic [15:0]       baud_q,     baud_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic              valid_q,    valid_d;

    // div = (total + 4) >> 3, evaluated at full width so an oversized
    // period is caught rather than wrapped.
    logic [DW-1:0] rnd_sum;
    logic [DW-1:0] div_full;
    logic [63:0]   div_ext;
    logic          div_ok;

    assign rnd_sum  = {1'b0, total_q} + {{(DW-3){1'b0}}, 3'd4};
    assign div_full = rnd_sum >> AB_SHIFT;
    assign div_ext  = {{(64-DW){1'b0}}, div_full};
    assign div_ok   = (div_ext >= 64'(MIN_BIT)) && (div_ext <= 64'h0000_FFFF);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            total_q    <= '0;
            baud_q     <= 16'(DEFAULT_DIV);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            total_q    <= total_d;
            baud_q     <= baud_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        total_d    = total_q;
        baud_d     = baud_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end

            // Arming during a low pulse must not treat its end as a start.
            WAIT_HIGH: begin
                if (rx_lvl) begin
                    state_d = WAIT_EDGE;
                end
            end

            WAIT_EDGE: begin
                if (rx_fall) begin
                    cnt_d      = '0;
                    edge_cnt_d = '0;
                    state_d    = MEASURE;
                end
            end

            // cnt holds (cycles since edge 1) - 1, so the edge-5 cycle sees
            // cnt = span - 1 and total = cnt + 1 is the exact span.
            MEASURE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rx_fall) begin
                    edge_cnt_d = edge_cnt_q + 3'd1;
                    if (edge_cnt_q == LAST_EDGE) begin
                        total_d = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
                        state_d = EVAL;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = FAIL;
                end
            end

            EVAL: begin
                if (div_ok) begin
                    baud_d  = div_ext[15:0];
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FAIL;
                end
            end

            FAIL: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign valid    = valid_q;
    assign baud_div = baud_q;

endmodule : uart_autobaud
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_autobaud
//  Purpose  : Directed self-checking bench for uart_autobaud. Drives 0x55
//             calibration frames at several bit periods, break and reset
//             corner cases, and checks the outputs against hand-computed
//             values.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_autobaud;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        rx_in  = 1'b1;
    logic        start  = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic        valid;
    logic [15:0] baud_div;

    int vectors     = 0;
    int miscompares = 0;

    int   done_seen     = 0;
    int   err_seen      = 0;
    int   both_seen     = 0;
    int   busy_at_pulse = 0;
    int   long_pulse    = 0;
    logic done_prev     = 1'b0;
    logic err_prev      = 1'b0;

    int seg [10];
    int d0;
    int e0;

    // Narrow counter keeps the break case short; 8 x 868 still fits.
    uart_autobaud #(
        .CNT_W       (14),
        .MIN_BIT     (4),
        .DEFAULT_DIV (868)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .rx_in    (rx_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .valid    (valid),
        .baud_div (baud_div)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (done) done_seen++;
        if (err)  err_seen++;
        if (done && err) both_seen++;
        if ((done || err) && busy) busy_at_pulse++;
        if ((done && done_prev) || (err && err_prev)) long_pulse++;
        done_prev = done;
        err_prev  = err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic set_bits(input int b);
        for (int i = 0; i < 10; i++) seg[i] = b;
    endtask

    // Start bit, then 1,0,1,0,1,0,1,0 (0x55 LSB first), then stop.
    task automatic play();
        for (int i = 0; i < 10; i++) begin
            rx_in = (i % 2 == 1);
            tick(seg[i]);
        end
        rx_in = 1'b1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic snap();
        d0 = done_seen;
        e0 = err_seen;
    endtask

    task automatic wait_result(input int budget);
        int n;
        n = 0;
        #1;
        while (done_seen == d0 && err_seen == e0 && n < budget) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        tick(3);
    endtask

    initial begin
        // Reset
        tick(3);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_valid", valid, 0);
        chk("rst_div",   baud_div, 868);
        rst = 1'b0;
        tick(2);

        // 115200 baud at 100 MHz: 868-cycle bits
        arm();
        chk("b868_busy_armed", busy, 1);
        tick(10);
        snap();
        set_bits(868);
        play();
        wait_result(200);
        chk("b868_done", done_seen - d0, 1);
        chk("b868_err",  err_seen - e0, 0);
        chk("b868_div",  baud_div, 868);
        chk("b868_valid", valid, 1);
        chk("b868_busy", busy, 0);

        // 10-cycle bits with jitter: edges at 0,21,39,61,81 -> (81+4)>>3 = 10
        arm();
        tick(10);
        seg = '{10, 11, 9, 9, 11, 11, 10, 10, 10, 10};
        snap();
        play();
        wait_result(200);
        chk("jit_done", done_seen - d0, 1);
        chk("jit_div",  baud_div, 10);
        chk("jit_busy", busy, 0);

        // 3-cycle bits: (24+4)>>3 = 3 < MIN_BIT
        arm();
        tick(10);
        snap();
        set_bits(3);
        play();
        wait_result(200);
        chk("short_err",   err_seen - e0, 1);
        chk("short_done",  done_seen - d0, 0);
        chk("short_div",   baud_div, 10);
        chk("short_valid", valid, 1);
        chk("short_busy",  busy, 0);

        // Break: rx held low until the counter saturates
        arm();
        tick(10);
        snap();
        rx_in = 1'b0;
        wait_result(20000);
        chk("brk_err",  err_seen - e0, 1);
        chk("brk_done", done_seen - d0, 0);
        chk("brk_busy", busy, 0);
        chk("brk_div",  baud_div, 10);
        rx_in = 1'b1;
        tick(10);

        // Arm mid-low, then 0x55 at 100-cycle bits with a stray start
        rx_in = 1'b0;
        tick(5);
        snap();
        arm();
        tick(50);
        chk("midlow_busy",  busy, 1);
        chk("midlow_quiet", (done_seen - d0) + (err_seen - e0), 0);
        rx_in = 1'b1;
        tick(20);
        set_bits(100);
        fork
            play();
            begin
                tick(300);
                arm();
            end
        join
        wait_result(200);
        chk("b100_done", done_seen - d0, 1);
        chk("b100_err",  err_seen - e0, 0);
        chk("b100_div",  baud_div, 100);
        chk("b100_busy", busy, 0);

        // Reset after three edges of a 50-cycle frame
        arm();
        tick(10);
        snap();
        set_bits(50);
        for (int i = 0; i < 5; i++) begin
            rx_in = (i % 2 == 1);
            tick(seg[i]);
        end
        rst   = 1'b1;
        rx_in = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_busy",  busy, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_div",   baud_div, 868);
        chk("midrst_quiet", (done_seen - d0) + (err_seen - e0), 0);
        tick(10);
        arm();
        tick(10);
        snap();
        set_bits(20);
        play();
        wait_result(200);
        chk("b20_done",  done_seen - d0, 1);
        chk("b20_div",   baud_div, 20);
        chk("b20_valid", valid, 1);

        // start coincident with rst
        rst   = 1'b1;
        start = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b0;
        tick(2);
        chk("rststart_busy", busy, 0);
        chk("rststart_div",  baud_div, 868);

        // Pulse properties gathered over the whole run
        chk("pulse_overlap",     both_seen, 0);
        chk("busy_high_at_pulse", busy_at_pulse, 0);
        chk("pulse_width",       long_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_autobaud
`default_nettype wire
